linescanner_capture_sequencer: RTL and testbench

//  Parametrised line-scan sensor front end: exposure/sample sequencer, ADC load-pulse generator and pixel framer.

---
 rtl/linescanner_capture_sequencer_pkg.sv | 39 +++
 rtl/linescanner_capture_sequencer_if.sv | 56 +++++
 rtl/linescanner_capture_sequencer_wait_timer.sv | 38 +++
 rtl/linescanner_capture_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_linescanner_capture_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/linescanner_capture_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : linescanner_pkg
// Description : Shared types and default constants for the line-scan capture
//               sequencer: exposure and load FSM state encodings, default
//               strobe timing and the width of the completed-line counter.
// Revision    : 1.0 - initial release
// ============================================================================
package linescanner_pkg;

    // Default strobe timing, in pixel_clock cycles
    localparam int C_T_RST_CVC     = 48;
    localparam int C_T_RST_CDS     = 7;
    localparam int C_T_SAMPLE      = 48;
    localparam int C_T_SAMPLE_HOLD = 6;
    localparam int C_T_LOAD_DELAY  = 3;

    localparam int C_LINE_COUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        EXP_IDLE      = 3'd0,
        EXP_CVC_LOW   = 3'd1,
        EXP_CDS_LOW   = 3'd2,
        EXP_WAIT_EOC  = 3'd3,
        EXP_SAMPLE_HI = 3'd4,
        EXP_SAMPLE_LO = 3'd5,
        EXP_RELEASE   = 3'd6
    } exp_state_t;

    typedef enum logic [2:0] {
        LD_WAIT_EOC_RE   = 3'd0,
        LD_WAIT_LVAL_LOW = 3'd1,
        LD_DELAY         = 3'd2,
        LD_LOAD          = 3'd3,
        LD_WAIT_EOC_FE   = 3'd4
    } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/linescanner_capture_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : linescanner_capture_sequencer_if
// Description : Sensor/ADC-side and pipeline-side signal bundle of the
//               capture sequencer.
//               master : acquisition controls and ADC inputs driven, status seen
//               slave  : the sequencer itself
//               Controls : enable, continuous, start
//               ADC in   : data, lval, end_adc
//               Strobes  : rst_cvc, rst_cds (active low), sample, load_pulse
//               Pixels   : pixel_data, pixel_valid, line_start, line_end,
//                          pixel_index, line_count, line_error, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface linescanner_capture_sequencer_if
    import linescanner_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int LINE_PIXELS = 1024
);
    localparam int IDX_WIDTH = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;

    logic                          enable;
    logic                          continuous;
    logic                          start;
    logic [DATA_WIDTH-1:0]         data;
    logic                          lval;
    logic                          end_adc;

    logic                          rst_cvc;
    logic                          rst_cds;
    logic                          sample;
    logic                          load_pulse;
    logic [DATA_WIDTH-1:0]         pixel_data;
    logic                          pixel_valid;
    logic                          line_start;
    logic                          line_end;
    logic [IDX_WIDTH-1:0]          pixel_index;
    logic [C_LINE_COUNT_WIDTH-1:0] line_count;
    logic                          line_error;
    logic                          busy;

    modport master (
        output enable, continuous, start, data, lval, end_adc,
        input  rst_cvc, rst_cds, sample, load_pulse, pixel_data, pixel_valid,
               line_start, line_end, pixel_index, line_count, line_error, busy
    );

    modport slave (
        input  enable, continuous, start, data, lval, end_adc,
        output rst_cvc, rst_cds, sample, load_pulse, pixel_data, pixel_valid,
               line_start, line_end, pixel_index, line_count, line_error, busy
    );

endinterface
`default_nettype wire

// File: rtl/linescanner_capture_sequencer_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : linescanner_wait_timer
// Description : Down-counter used to time FSM states. A load on state entry
//               arms it with T-1 (T=0 behaves as T=1); done is high while the
//               count is zero, so a state that leaves on done lasts T cycles.
//               clk, rst   : clock, synchronous active-high reset
//               load       : arm the timer with load_value
//               load_value : state duration in cycles
//               done       : count has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module linescanner_wait_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 load,
    input  wire logic [CNT_WIDTH-1:0] load_value,
    output logic                      done
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= (load_value == '0) ? '0 : load_value - 1'b1;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/linescanner_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : linescanner_capture_sequencer
// Description : Line-scan sensor front end. An exposure FSM drives the
//               rst_cvc / rst_cds / sample strobes, a load FSM issues the ADC
//               load pulse after each conversion, and a framer turns the lval
//               qualified ADC stream into indexed, counted lines with a
//               length check.
//               pixel_clock : sole clock, rising edge
//               reset       : synchronous, active-high
//               bus         : slave side of linescanner_capture_sequencer_if
// Revision    : 1.0 - initial release
// ============================================================================
module linescanner_capture_sequencer
    import linescanner_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int LINE_PIXELS   = 1024,
    parameter int T_RST_CVC     = C_T_RST_CVC,
    parameter int T_RST_CDS     = C_T_RST_CDS,
    parameter int T_SAMPLE      = C_T_SAMPLE,
    parameter int T_SAMPLE_HOLD = C_T_SAMPLE_HOLD,
    parameter int T_LOAD_DELAY  = C_T_LOAD_DELAY,
    parameter int CNT_WIDTH     = 8
) (
    input  wire logic                      pixel_clock,
    input  wire logic                      reset,
    linescanner_capture_sequencer_if.slave bus
);

    localparam int IDX_W     = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    // Window counter needs one value past LINE_PIXELS to flag long lines
    localparam int PIX_CNT_W = $clog2(LINE_PIXELS + 2);

    localparam logic [CNT_WIDTH-1:0] C_CNT_CVC  = CNT_WIDTH'(T_RST_CVC);
    localparam logic [CNT_WIDTH-1:0] C_CNT_CDS  = CNT_WIDTH'(T_RST_CDS);
    localparam logic [CNT_WIDTH-1:0] C_CNT_SMP  = CNT_WIDTH'(T_SAMPLE);
    localparam logic [CNT_WIDTH-1:0] C_CNT_HOLD = CNT_WIDTH'(T_SAMPLE_HOLD);
    localparam logic [CNT_WIDTH-1:0] C_CNT_LOAD = CNT_WIDTH'(T_LOAD_DELAY);

    localparam logic [PIX_CNT_W-1:0] C_LINE_LEN = PIX_CNT_W'(LINE_PIXELS);
    localparam logic [PIX_CNT_W-1:0] C_LAST_PIX = PIX_CNT_W'(LINE_PIXELS - 1);
    localparam logic [PIX_CNT_W-1:0] C_PIX_SAT  = PIX_CNT_W'(LINE_PIXELS + 1);

    // ------------------------------------------------------------------
    // Exposure FSM
    // ------------------------------------------------------------------
    exp_state_t           r_exp_state;
    exp_state_t           w_exp_next;
    logic                 w_exp_load;
    logic [CNT_WIDTH-1:0] w_exp_value;
    logic                 w_exp_done;

    always_ff @(posedge pixel_clock) begin
        if (reset) r_exp_state <= EXP_IDLE;
        else       r_exp_state <= w_exp_next;
    end

    always_comb begin
        w_exp_next  = r_exp_state;
        w_exp_load  = 1'b0;
        w_exp_value = '0;
        case (r_exp_state)
            EXP_IDLE: begin
                if (bus.enable && (bus.continuous || bus.start)) begin
                    w_exp_next  = EXP_CVC_LOW;
                    w_exp_load  = 1'b1;
                    w_exp_value = C_CNT_CVC;
                end
            end
            EXP_CVC_LOW: begin
                if (w_exp_done) begin
                    w_exp_next  = EXP_CDS_LOW;
                    w_exp_load  = 1'b1;
                    w_exp_value = C_CNT_CDS;
                end
            end
            EXP_CDS_LOW: begin
                if (w_exp_done) w_exp_next = EXP_WAIT_EOC;
            end
            EXP_WAIT_EOC: begin
                if (bus.end_adc) begin
                    w_exp_next  = EXP_SAMPLE_HI;
                    w_exp_load  = 1'b1;
                    w_exp_value = C_CNT_SMP;
                end
            end
            EXP_SAMPLE_HI: begin
                if (w_exp_done) begin
                    w_exp_next  = EXP_SAMPLE_LO;
                    w_exp_load  = 1'b1;
                    w_exp_value = C_CNT_HOLD;
                end
            end
            EXP_SAMPLE_LO: begin
                if (w_exp_done) w_exp_next = EXP_RELEASE;
            end
            EXP_RELEASE: w_exp_next = EXP_IDLE;
            default:     w_exp_next = EXP_IDLE;
        endcase
    end

    linescanner_wait_timer #(.CNT_WIDTH(CNT_WIDTH)) u_exp_timer (
        .clk        (pixel_clock),
        .rst        (reset),
        .load       (w_exp_load),
        .load_value (w_exp_value),
        .done       (w_exp_done)
    );

    // Strobes decode straight from the state register so each edge lands on
    // the clock that enters/leaves the corresponding state.
    logic w_rst_cvc;
    logic w_rst_cds;
    logic w_sample;

    always_comb begin
        w_rst_cvc = 1'b1;
        w_rst_cds = 1'b1;
        w_sample  = 1'b0;
        case (r_exp_state)
            EXP_CVC_LOW: w_rst_cvc = 1'b0;
            EXP_CDS_LOW, EXP_WAIT_EOC, EXP_SAMPLE_LO: begin
                w_rst_cvc = 1'b0;
                w_rst_cds = 1'b0;
            end
            EXP_SAMPLE_HI: begin
                w_rst_cvc = 1'b0;
                w_rst_cds = 1'b0;
                w_sample  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.rst_cvc = w_rst_cvc;
    assign bus.rst_cds = w_rst_cds;
    assign bus.sample  = w_sample;
    assign bus.busy    = (r_exp_state != EXP_IDLE);

    // ------------------------------------------------------------------
    // Load FSM: one ADC load pulse per conversion, issued only once the
    // current lval window (if any) has closed.
    // ------------------------------------------------------------------
    ld_state_t            r_ld_state;
    ld_state_t            w_ld_next;
    logic                 w_ld_load;
    logic                 w_ld_done;

    always_ff @(posedge pixel_clock) begin
        if (reset) r_ld_state <= LD_WAIT_EOC_RE;
        else       r_ld_state <= w_ld_next;
    end

    always_comb begin
        w_ld_next = r_ld_state;
        w_ld_load = 1'b0;
        case (r_ld_state)
            // Level test is edge-equivalent: WAIT_EOC_FE guarantees end_adc
            // was seen low before returning here.
            LD_WAIT_EOC_RE: begin
                if (bus.end_adc) begin
                    if (bus.lval) begin
                        w_ld_next = LD_WAIT_LVAL_LOW;
                    end else begin
                        w_ld_next = LD_DELAY;
                        w_ld_load = 1'b1;
                    end
                end
            end
            LD_WAIT_LVAL_LOW: begin
                if (!bus.lval) begin
                    w_ld_next = LD_DELAY;
                    w_ld_load = 1'b1;
                end
            end
            LD_DELAY: begin
                if (w_ld_done) w_ld_next = LD_LOAD;
            end
            LD_LOAD:        w_ld_next = LD_WAIT_EOC_FE;
            LD_WAIT_EOC_FE: begin
                if (!bus.end_adc) w_ld_next = LD_WAIT_EOC_RE;
            end
            default:        w_ld_next = LD_WAIT_EOC_RE;
        endcase
    end

    linescanner_wait_timer #(.CNT_WIDTH(CNT_WIDTH)) u_ld_timer (
        .clk        (pixel_clock),
        .rst        (reset),
        .load       (w_ld_load),
        .load_value (C_CNT_LOAD),
        .done       (w_ld_done)
    );

    assign bus.load_pulse = (r_ld_state == LD_LOAD);

    // ------------------------------------------------------------------
    // Pixel framer
    // ------------------------------------------------------------------
    logic                          r_lval_d;
    logic [PIX_CNT_W-1:0]          r_pix_cnt;   // pixels seen in current window, saturating
    logic [DATA_WIDTH-1:0]         r_pixel_data;
    logic                          r_pixel_valid;
    logic                          r_line_start;
    logic                          r_line_end;
    logic [IDX_W-1:0]              r_pixel_index;
    logic [C_LINE_COUNT_WIDTH-1:0] r_line_count;
    logic                          r_line_error;

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            r_lval_d      <= 1'b0;
            r_pix_cnt     <= '0;
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
            r_line_start  <= 1'b0;
            r_line_end    <= 1'b0;
            r_pixel_index <= '0;
            r_line_count  <= '0;
            r_line_error  <= 1'b0;
        end else begin
            r_lval_d      <= bus.lval;
            r_pixel_valid <= 1'b0;
            r_line_start  <= 1'b0;
            r_line_end    <= 1'b0;
            r_line_error  <= 1'b0;
            if (bus.lval) begin
                if (r_pix_cnt < C_LINE_LEN) begin
                    r_pixel_data  <= bus.data;
                    r_pixel_valid <= 1'b1;
                    r_pixel_index <= r_pix_cnt[IDX_W-1:0];
                    r_line_start  <= (r_pix_cnt == '0);
                    r_line_end    <= (r_pix_cnt == C_LAST_PIX);
                end
                if (r_pix_cnt != C_PIX_SAT) begin
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                end
            end else begin
                r_pix_cnt <= '0;
                if (r_lval_d) begin
                    r_line_count <= r_line_count + 1'b1;
                    r_line_error <= (r_pix_cnt != C_LINE_LEN);
                end
            end
        end
    end

    assign bus.pixel_data  = r_pixel_data;
    assign bus.pixel_valid = r_pixel_valid;
    assign bus.line_start  = r_line_start;
    assign bus.line_end    = r_line_end;
    assign bus.pixel_index = r_pixel_index;
    assign bus.line_count  = r_line_count;
    assign bus.line_error  = r_line_error;

endmodule
`default_nettype wire

// File: tb/tb_linescanner_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_linescanner_capture_sequencer
// Description : Directed bench for linescanner_capture_sequencer with
//               LINE_PIXELS=16 and default timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_linescanner_capture_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    linescanner_capture_sequencer_if #(.DATA_WIDTH(8), .LINE_PIXELS(16)) bus ();

    linescanner_capture_sequencer #(
        .DATA_WIDTH  (8),
        .LINE_PIXELS (16)
    ) dut (
        .pixel_clock (clk),
        .reset       (reset),
        .bus         (bus)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.rst_cvc;
            1:       return bus.rst_cds;
            2:       return bus.sample;
            default: return bus.busy;
        endcase
    endfunction

    // Cycles for which the selected signal keeps the given level (bounded)
    task automatic run_len(input int sel, input logic lvl, output int n);
        n = 0;
        while (sig(sel) === lvl && n < 500) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  nvalid;
        int  nend;
        bit  seen;

        bus.enable = 0; bus.continuous = 0; bus.start = 0;
        bus.data = '0; bus.lval = 0; bus.end_adc = 0;

        // ---- reset state ----
        tick(3);
        chk("rst_rst_cvc",    32'(bus.rst_cvc), 1);
        chk("rst_rst_cds",    32'(bus.rst_cds), 1);
        chk("rst_sample",     32'(bus.sample), 0);
        chk("rst_load_pulse", 32'(bus.load_pulse), 0);
        chk("rst_valid",      32'(bus.pixel_valid), 0);
        chk("rst_index",      32'(bus.pixel_index), 0);
        chk("rst_line_count", 32'(bus.line_count), 0);
        chk("rst_line_error", 32'(bus.line_error), 0);
        chk("rst_busy",       32'(bus.busy), 0);
        reset = 0;
        tick();

        // ---- continuous acquisition, end_adc 60 cycles after rst_cvc falls ----
        bus.enable = 1; bus.continuous = 1;
        tick();
        chk("c1_cvc_fall", 32'(bus.rst_cvc), 0);
        chk("c1_busy", 32'(bus.busy), 1);
        run_len(1, 1'b1, n);
        chk("c1_cvc_len", 32'(n), 48);
        tick(12);
        chk("c1_wait_sample", 32'(bus.sample), 0);
        chk("c1_wait_cds", 32'(bus.rst_cds), 0);
        bus.end_adc = 1;
        tick();
        chk("c1_sample_rise", 32'(bus.sample), 1);
        run_len(2, 1'b1, n);
        chk("c1_sample_len", 32'(n), 48);
        chk("c1_hold_cds", 32'(bus.rst_cds), 0);
        run_len(0, 1'b0, n);
        chk("c1_hold_len", 32'(n), 6);
        chk("c1_release_cds", 32'(bus.rst_cds), 1);
        chk("c1_release_busy", 32'(bus.busy), 1);
        tick();
        chk("c1_idle_busy", 32'(bus.busy), 0);
        tick();
        chk("c2_b2b_cvc", 32'(bus.rst_cvc), 0);
        // drop enable mid-cycle: this cycle must still complete
        bus.enable = 0;
        run_len(1, 1'b1, n);
        chk("c2_cvc_len", 32'(n), 48);
        run_len(2, 1'b0, n);
        chk("c2_cds_poll_len", 32'(n), 8);
        run_len(2, 1'b1, n);
        chk("c2_sample_len", 32'(n), 48);
        run_len(0, 1'b0, n);
        chk("c2_hold_len", 32'(n), 6);
        chk("c2_release_busy", 32'(bus.busy), 1);
        tick(6);
        chk("c2_stays_idle", 32'(bus.busy), 0);
        chk("c2_idle_cvc", 32'(bus.rst_cvc), 1);
        bus.end_adc = 0;
        tick(2);

        // ---- single shot ----
        bus.continuous = 0; bus.enable = 1; bus.end_adc = 1; bus.start = 1;
        tick();
        bus.start = 0;
        chk("ss_busy", 32'(bus.busy), 1);
        chk("ss_cvc", 32'(bus.rst_cvc), 0);
        tick(5);
        bus.start = 1;
        tick();
        bus.start = 0;
        run_len(3, 1'b1, n);
        chk("ss_busy_len", 32'(n), 105);
        tick(20);
        chk("ss_one_cycle_busy", 32'(bus.busy), 0);
        chk("ss_one_cycle_cvc", 32'(bus.rst_cvc), 1);
        bus.enable = 0; bus.end_adc = 0;
        tick(2);

        // ---- load pulse after lval falls (also a 10-pixel short line) ----
        bus.lval = 1; bus.end_adc = 1; bus.data = 8'hA5;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.load_pulse) seen = 1;
        end
        chk("lp_none_in_lval", 32'(seen), 0);
        bus.lval = 0;
        tick();
        chk("lp_k1", 32'(bus.load_pulse), 0);
        chk("lp_short_error", 32'(bus.line_error), 1);
        chk("lp_line_count", 32'(bus.line_count), 1);
        tick();
        chk("lp_k2", 32'(bus.load_pulse), 0);
        tick();
        chk("lp_k3", 32'(bus.load_pulse), 0);
        tick();
        chk("lp_k4_pulse", 32'(bus.load_pulse), 1);
        tick();
        chk("lp_k5", 32'(bus.load_pulse), 0);
        bus.end_adc = 0;
        tick(2);

        // ---- exact 16-pixel line ----
        for (int i = 0; i < 16; i++) begin
            bus.lval = 1; bus.data = 8'(i);
            tick();
            chk($sformatf("l16_valid%0d", i), 32'(bus.pixel_valid), 1);
            chk($sformatf("l16_index%0d", i), 32'(bus.pixel_index), 32'(i));
            chk($sformatf("l16_data%0d", i), 32'(bus.pixel_data), 32'(i));
            chk($sformatf("l16_start%0d", i), 32'(bus.line_start), (i == 0) ? 1 : 0);
            chk($sformatf("l16_end%0d", i), 32'(bus.line_end), (i == 15) ? 1 : 0);
        end
        bus.lval = 0;
        tick();
        chk("l16_valid_off", 32'(bus.pixel_valid), 0);
        chk("l16_line_count", 32'(bus.line_count), 2);
        chk("l16_no_error", 32'(bus.line_error), 0);
        tick(2);

        // ---- 12-pixel short line ----
        nvalid = 0; nend = 0;
        for (int i = 0; i < 12; i++) begin
            bus.lval = 1; bus.data = 8'(i + 100);
            tick();
            nvalid += int'(bus.pixel_valid);
            nend   += int'(bus.line_end);
        end
        bus.lval = 0;
        tick();
        chk("l12_valid_cnt", 32'(nvalid), 12);
        chk("l12_no_line_end", 32'(nend), 0);
        chk("l12_error", 32'(bus.line_error), 1);
        chk("l12_line_count", 32'(bus.line_count), 3);
        tick();
        chk("l12_error_1cyc", 32'(bus.line_error), 0);
        tick();

        // ---- 20-pixel long line ----
        nvalid = 0; nend = 0;
        for (int i = 0; i < 20; i++) begin
            bus.lval = 1; bus.data = 8'(i + 50);
            tick();
            nvalid += int'(bus.pixel_valid);
            nend   += int'(bus.line_end);
        end
        bus.lval = 0;
        tick();
        chk("l20_valid_cnt", 32'(nvalid), 16);
        chk("l20_line_end_cnt", 32'(nend), 1);
        chk("l20_last_data", 32'(bus.pixel_data), 32'd65);
        chk("l20_error", 32'(bus.line_error), 1);
        chk("l20_line_count", 32'(bus.line_count), 4);
        tick(2);

        // ---- reset in the middle of SAMPLE_HI ----
        bus.enable = 1; bus.continuous = 1; bus.end_adc = 1;
        n = 0;
        while (bus.sample !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk("mr_reached_sample", 32'(bus.sample), 1);
        tick(5);
        reset = 1;
        tick();
        chk("mr_sample", 32'(bus.sample), 0);
        chk("mr_cvc", 32'(bus.rst_cvc), 1);
        chk("mr_cds", 32'(bus.rst_cds), 1);
        chk("mr_busy", 32'(bus.busy), 0);
        chk("mr_line_count", 32'(bus.line_count), 0);
        chk("mr_index", 32'(bus.pixel_index), 0);
        bus.enable = 0; bus.continuous = 0; bus.end_adc = 0;
        reset = 0;
        tick(3);
        chk("mr_idle_after", 32'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
